seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/hex_to_7seg.sv | 13 +
 rtl/seven_seg_scan.sv | 102 ++++++++++
 tb/tb_seven_seg_scan.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared definitions for the seven-segment scanner.
//   ST_BLANK / ST_SHOW : scan FSM state encoding
//   SEG_BLANK          : all cathodes off (active-low)
//   AN_OFF             : all anodes off (active-low)
//   HEX_SEG            : 16-entry active-low {g,f,e,d,c,b,a} hex font
package seven_seg_pkg;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Entry 15 first so HEX_SEG[v] selects the glyph for value v.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex-digit to active-low segment decoder.
//   hex   : 4-bit value
//   seg_n : active-low cathodes {g,f,e,d,c,b,a}
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a 4-digit common-anode display.
// Each digit slot is BLANK_CYCLES of all-off guard followed by SHOW_CYCLES lit.
// The input word is captured once per frame so a frame never mixes old and
// new data.
//   HCLK, HRESET : clock, asynchronous active-high reset
//   D_7SEG       : four hex nibbles, nibble k drives digit k
//   EN_7SEG      : [3:0] digit enables, [7:4] decimal points
//   SEG_n, DP_n  : active-low cathodes / decimal point
//   AN_n         : active-low anodes, [7:4] tied off
//   FRAME_START  : one-cycle pulse on the edge a new frame is captured
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [15:0] D_7SEG,
    input  logic [7:0]  EN_7SEG,
    output logic [6:0]  SEG_n,
    output logic        DP_n,
    output logic [7:0]  AN_n,
    output logic        FRAME_START
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      sh_d, sh_d_nxt;
    logic [7:0]       sh_en, sh_en_nxt;
    logic             capture;
    logic             lit;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        capture   = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    capture   = (idx == 2'd0);
                end
            end
            default: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                end
            end
        endcase
    end

    // Outputs are computed from next-state values so they change on the
    // same edge as the FSM; on a capture edge that means the live inputs
    // feed the decoder directly, bypassing the shadow registers.
    assign sh_d_nxt  = capture ? D_7SEG  : sh_d;
    assign sh_en_nxt = capture ? EN_7SEG : sh_en;
    assign nib       = sh_d_nxt[{idx_nxt, 2'b00} +: 4];
    assign lit       = (state_nxt == ST_SHOW) && sh_en_nxt[{1'b0, idx_nxt}];

    hex_to_7seg u_dec (
        .hex   (nib),
        .seg_n (dec_seg)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            idx         <= '0;
            sh_d        <= '0;
            sh_en       <= '0;
            AN_n        <= AN_OFF;
            SEG_n       <= SEG_BLANK;
            DP_n        <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            sh_d        <= sh_d_nxt;
            sh_en       <= sh_en_nxt;
            AN_n        <= lit ? {4'hF, ~(4'b0001 << idx_nxt)} : AN_OFF;
            SEG_n       <= lit ? dec_seg : SEG_BLANK;
            DP_n        <= lit ? ~sh_en_nxt[{1'b1, idx_nxt}] : 1'b1;
            FRAME_START <= capture;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench. Stimulus pushes the expected lit slots
// of each frame it programs; a negedge monitor pops one entry at the start of
// every lit slot and also checks blanking, slot length, anode one-hotness and
// FRAME_START timing.
module tb_seven_seg_scan;

    localparam int SHOW   = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = 4 * (SHOW + BLANK);

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic [15:0] D_7SEG = '0;
    logic [7:0]  EN_7SEG = '0;
    logic [6:0]  SEG_n;
    logic        DP_n;
    logic [7:0]  AN_n;
    logic        FRAME_START;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   run = 0;
    int   last_fs = 0;
    bit   have_fs = 1'b0;
    bit   after_rst = 1'b0;
    logic [7:0] prev_an = 8'hFF;

    seven_seg_scan #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .D_7SEG      (D_7SEG),
        .EN_7SEG     (EN_7SEG),
        .SEG_n       (SEG_n),
        .DP_n        (DP_n),
        .AN_n        (AN_n),
        .FRAME_START (FRAME_START)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Expected lit slots of one frame; disabled digits produce no slot.
    task automatic push_frame(input logic [15:0] d, input logic [7:0] en);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) begin
                e.an  = {4'hF, ~(4'b0001 << k)};
                e.seg = exp_seg(d[4*k +: 4]);
                e.dp  = ~en[4+k];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_fs();
        for (int n = 0; n < 64; n++) begin
            @(negedge HCLK);
            if (FRAME_START === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_fs: FRAME_START stayed 0 for 64 cycles, expected a pulse");
    endtask

    // Monitor
    always @(negedge HCLK) begin
        check("an_onehot", 32'(($countones(~AN_n) <= 1) && (AN_n[7:4] == 4'hF)), 32'd1);
        if (HRESET) begin
            after_rst = 1'b1;
            check("reset_out", 32'({AN_n, SEG_n, DP_n, FRAME_START}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
        end
        if (AN_n == 8'hFF) begin
            check("blank_out", 32'({SEG_n, DP_n}), 32'({7'h7F, 1'b1}));
            if (prev_an != 8'hFF && !HRESET) check("slot_len", 32'(run), 32'(SHOW));
            run = 0;
        end else if (prev_an == 8'hFF) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL slot: got unexpected lit slot AN_n=%h SEG_n=%h, expected no slot", AN_n, SEG_n);
                cur = {AN_n, SEG_n, DP_n};
            end else begin
                cur = exp_q.pop_front();
                check("slot", 32'({AN_n, SEG_n, DP_n}), 32'(cur));
            end
            run = 1;
        end else begin
            check("slot_hold", 32'({AN_n, SEG_n, DP_n}), 32'(cur));
            run++;
        end
        if (FRAME_START) begin
            if (after_rst) begin
                check("fs_after_reset", 32'(cyc - rel_cyc), 32'(BLANK));
                after_rst = 1'b0;
            end else if (have_fs) begin
                check("fs_period", 32'(cyc - last_fs), 32'(PERIOD));
            end
            have_fs = 1'b1;
            last_fs = cyc;
        end
        prev_an = AN_n;
    end

    // Stimulus
    initial begin
        logic [15:0] d;
        logic [7:0]  en;
        #1 HRESET = 1'b1;
        D_7SEG  = 16'h1234;
        EN_7SEG = 8'h0F;
        repeat (3) @(posedge HCLK);
        #1;
        push_frame(16'h1234, 8'h0F);
        HRESET  = 1'b0;
        rel_cyc = cyc;

        // Frame 1 (1234) now showing; program sparse enables for frame 2.
        // Nibble 2 of ABCD is B, so digit 2 shows 03.
        wait_fs();
        D_7SEG = 16'hABCD; EN_7SEG = 8'h25;
        push_frame(16'hABCD, 8'h25);

        wait_fs();
        D_7SEG = 16'h0000; EN_7SEG = 8'h0F;
        push_frame(16'h0000, 8'h0F);

        // Frame 3 (0000) showing; change data during digit 2's slot.
        wait_fs();
        repeat (13) @(posedge HCLK);
        #1 D_7SEG = 16'hFFFF;
        push_frame(16'hFFFF, 8'h0F);

        // Frame 4 (FFFF) showing; reset in the middle of digit 3's slot.
        // The post-reset frame captures 1234/0F.
        wait_fs();
        D_7SEG = 16'h1234; EN_7SEG = 8'h0F;
        push_frame(16'h1234, 8'h0F);
        repeat (19) @(posedge HCLK);
        #1;
        check("pre_reset_an", 32'(AN_n), 32'(8'hF7));
        HRESET = 1'b1;
        #1 check("reset_async", 32'({AN_n, SEG_n, DP_n}), 32'({8'hFF, 7'h7F, 1'b1}));
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        rel_cyc = cyc;

        for (int i = 0; i < 10; i++) begin
            wait_fs();
            d  = 16'h0123 + 16'(i) * 16'h1111;
            en = (i % 2 == 1) ? 8'h3C : 8'hFF;
            D_7SEG  = d;
            EN_7SEG = en;
            push_frame(d, en);
        end
        wait_fs();
        repeat (PERIOD) @(negedge HCLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
